// File: rtl/sram_ctrl.sv
// Serialises CPU fetch and data accesses onto two asynchronous 32-bit SRAMs.
// Data accesses win over fetches; every pin and completion flag comes from a register.
module sram_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        iread_ce,
    input  logic [31:0] irom_addr,
    output logic [31:0] rom_inst,
    output logic        rfin_c,

    input  logic        dread_ce,
    input  logic        dwrite_ce,
    input  logic [31:0] drom_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rom_rdata,
    output logic        rfin_a,
    output logic        wfin_a,

    inout  wire  [31:0] base_ram_data,
    output logic [19:0] base_ram_addr,
    output logic [3:0]  base_ram_be_n,
    output logic        base_ram_ce_n,
    output logic        base_ram_oe_n,
    output logic        base_ram_we_n,

    inout  wire  [31:0] ext_ram_data,
    output logic [19:0] ext_ram_addr,
    output logic [3:0]  ext_ram_be_n,
    output logic        ext_ram_ce_n,
    output logic        ext_ram_oe_n,
    output logic        ext_ram_we_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_DONE
    } state_t;

    localparam logic [2:0] C_RD_LOAD    = 3'(WAIT_CYCLES);
    localparam logic [2:0] C_PULSE_LOAD = 3'(WAIT_CYCLES - 1);
    localparam logic [8:0] C_REGION     = 9'b1000_0000_0;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [19:0] r_ramAddr;
    logic [31:0] r_wdata;
    logic        r_selExt;
    logic        r_isFetch;
    logic        r_baseCeN;
    logic        r_baseOeN;
    logic        r_baseWeN;
    logic        r_extCeN;
    logic        r_extOeN;
    logic        r_extWeN;
    logic        r_baseDrive;
    logic        r_extDrive;
    logic [31:0] r_romInst;
    logic [31:0] r_romRdata;
    logic        r_rfinC;
    logic        r_rfinA;
    logic        r_wfinA;

    logic        w_reqAny;
    logic        w_reqWrite;
    logic        w_reqDread;
    logic        w_reqFetch;
    logic [31:0] w_reqAddr;
    logic        w_reqInRange;
    logic        w_nextSelExt;
    logic [31:0] w_busIn;
    logic        w_unused;

    state_t      w_nextState;
    logic [2:0]  w_nextCnt;
    logic        w_accept;
    logic        w_ceN;
    logic        w_oeN;
    logic        w_weN;
    logic        w_drive;
    logic        w_finC;
    logic        w_finA;
    logic        w_finW;
    logic        w_loadInst;
    logic        w_loadData;
    logic [31:0] w_resultValue;

    // A simultaneous write and read is a write only; the read is not acknowledged.
    assign w_reqWrite   = dwrite_ce;
    assign w_reqDread   = !dwrite_ce && dread_ce;
    assign w_reqFetch   = !dwrite_ce && !dread_ce && iread_ce;
    assign w_reqAny     = dwrite_ce || dread_ce || iread_ce;
    assign w_reqAddr    = (dwrite_ce || dread_ce) ? drom_addr : irom_addr;
    assign w_reqInRange = (w_reqAddr[31:23] == C_REGION);
    assign w_nextSelExt = (r_state == S_IDLE) ? w_reqAddr[22] : r_selExt;
    assign w_busIn      = r_selExt ? ext_ram_data : base_ram_data;
    assign w_unused     = ^w_reqAddr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // The w_ceN/w_oeN/w_weN/w_drive values describe the state being entered, so the pins line up with it.
    always_comb begin
        w_nextState   = r_state;
        w_nextCnt     = (r_cnt != 3'd0) ? r_cnt - 3'd1 : 3'd0;
        w_accept      = 1'b0;
        w_ceN         = 1'b1;
        w_oeN         = 1'b1;
        w_weN         = 1'b1;
        w_drive       = 1'b0;
        w_finC        = 1'b0;
        w_finA        = 1'b0;
        w_finW        = 1'b0;
        w_loadInst    = 1'b0;
        w_loadData    = 1'b0;
        w_resultValue = 32'h0;

        case (r_state)
            S_IDLE: begin
                if (w_reqAny) begin
                    w_accept = 1'b1;
                    if (!w_reqInRange) begin
                        w_nextState = S_DONE;
                        w_finC      = w_reqFetch;
                        w_finA      = w_reqDread;
                        w_finW      = w_reqWrite;
                        w_loadInst  = w_reqFetch;
                        w_loadData  = w_reqDread;
                    end else if (w_reqWrite) begin
                        w_nextState = S_WR_SETUP;
                        w_ceN       = 1'b0;
                        w_drive     = 1'b1;
                    end else begin
                        w_nextState = S_RD;
                        w_nextCnt   = C_RD_LOAD;
                        w_ceN       = 1'b0;
                        w_oeN       = 1'b0;
                    end
                end
            end

            S_RD: begin
                if (r_cnt == 3'd0) begin
                    w_nextState   = S_DONE;
                    w_finC        = r_isFetch;
                    w_finA        = !r_isFetch;
                    w_loadInst    = r_isFetch;
                    w_loadData    = !r_isFetch;
                    w_resultValue = w_busIn;
                end else begin
                    w_ceN = 1'b0;
                    w_oeN = 1'b0;
                end
            end

            S_WR_SETUP: begin
                w_nextState = S_WR_PULSE;
                w_nextCnt   = C_PULSE_LOAD;
                w_ceN       = 1'b0;
                w_weN       = 1'b0;
                w_drive     = 1'b1;
            end

            S_WR_PULSE: begin
                w_ceN   = 1'b0;
                w_drive = 1'b1;
                if (r_cnt == 3'd0) begin
                    w_nextState = S_WR_HOLD;
                end else begin
                    w_weN = 1'b0;
                end
            end

            S_WR_HOLD: begin
                w_nextState = S_DONE;
                w_finW      = 1'b1;
            end

            S_DONE: begin
                w_nextState = S_IDLE;
            end

            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ramAddr  <= 20'h0;
            r_wdata    <= 32'h0;
            r_selExt   <= 1'b0;
            r_isFetch  <= 1'b0;
            r_romInst  <= 32'h0;
            r_romRdata <= 32'h0;
            r_rfinC    <= 1'b0;
            r_rfinA    <= 1'b0;
            r_wfinA    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ramAddr <= w_reqAddr[21:2];
                r_wdata   <= wdata;
                r_selExt  <= w_reqAddr[22];
                r_isFetch <= w_reqFetch;
            end
            if (w_loadInst) begin
                r_romInst <= w_resultValue;
            end
            if (w_loadData) begin
                r_romRdata <= w_resultValue;
            end
            r_rfinC <= w_finC;
            r_rfinA <= w_finA;
            r_wfinA <= w_finW;
        end
    end

    // Only the RAM picked by the captured address bit 22 ever sees an active strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baseCeN   <= 1'b1;
            r_baseOeN   <= 1'b1;
            r_baseWeN   <= 1'b1;
            r_extCeN    <= 1'b1;
            r_extOeN    <= 1'b1;
            r_extWeN    <= 1'b1;
            r_baseDrive <= 1'b0;
            r_extDrive  <= 1'b0;
        end else begin
            r_baseCeN   <= w_ceN | w_nextSelExt;
            r_baseOeN   <= w_oeN | w_nextSelExt;
            r_baseWeN   <= w_weN | w_nextSelExt;
            r_extCeN    <= w_ceN | !w_nextSelExt;
            r_extOeN    <= w_oeN | !w_nextSelExt;
            r_extWeN    <= w_weN | !w_nextSelExt;
            r_baseDrive <= w_drive & !w_nextSelExt;
            r_extDrive  <= w_drive & w_nextSelExt;
        end
    end

    assign base_ram_data = r_baseDrive ? r_wdata : 32'bz;
    assign ext_ram_data  = r_extDrive  ? r_wdata : 32'bz;

    assign base_ram_addr = r_ramAddr;
    assign ext_ram_addr  = r_ramAddr;
    assign base_ram_be_n = 4'b0000;
    assign ext_ram_be_n  = 4'b0000;
    assign base_ram_ce_n = r_baseCeN;
    assign base_ram_oe_n = r_baseOeN;
    assign base_ram_we_n = r_baseWeN;
    assign ext_ram_ce_n  = r_extCeN;
    assign ext_ram_oe_n  = r_extOeN;
    assign ext_ram_we_n  = r_extWeN;

    assign rom_inst  = r_romInst;
    assign rom_rdata = r_romRdata;
    assign rfin_c    = r_rfinC;
    assign rfin_a    = r_rfinA;
    assign wfin_a    = r_wfinA;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with behavioural models of both asynchronous SRAMs.
// Expected words, addresses and cycle counts are hand-derived constants.
module tb_sram_ctrl;

    logic        clk;
    logic        rst;
    logic        iread_ce;
    logic [31:0] irom_addr;
    logic [31:0] rom_inst;
    logic        rfin_c;
    logic        dread_ce;
    logic        dwrite_ce;
    logic [31:0] drom_addr;
    logic [31:0] wdata;
    logic [31:0] rom_rdata;
    logic        rfin_a;
    logic        wfin_a;
    wire  [31:0] base_ram_data;
    logic [19:0] base_ram_addr;
    logic [3:0]  base_ram_be_n;
    logic        base_ram_ce_n;
    logic        base_ram_oe_n;
    logic        base_ram_we_n;
    wire  [31:0] ext_ram_data;
    logic [19:0] ext_ram_addr;
    logic [3:0]  ext_ram_be_n;
    logic        ext_ram_ce_n;
    logic        ext_ram_oe_n;
    logic        ext_ram_we_n;

    int checkCount = 0;
    int errorCount = 0;

    sram_ctrl #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .iread_ce(iread_ce), .irom_addr(irom_addr), .rom_inst(rom_inst), .rfin_c(rfin_c),
        .dread_ce(dread_ce), .dwrite_ce(dwrite_ce), .drom_addr(drom_addr), .wdata(wdata),
        .rom_rdata(rom_rdata), .rfin_a(rfin_a), .wfin_a(wfin_a),
        .base_ram_data(base_ram_data), .base_ram_addr(base_ram_addr), .base_ram_be_n(base_ram_be_n),
        .base_ram_ce_n(base_ram_ce_n), .base_ram_oe_n(base_ram_oe_n), .base_ram_we_n(base_ram_we_n),
        .ext_ram_data(ext_ram_data), .ext_ram_addr(ext_ram_addr), .ext_ram_be_n(ext_ram_be_n),
        .ext_ram_ce_n(ext_ram_ce_n), .ext_ram_oe_n(ext_ram_oe_n), .ext_ram_we_n(ext_ram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models and activity monitor; all counters are only ever written here.
    logic [31:0] baseMem [logic [19:0]];
    logic [31:0] extMem  [logic [19:0]];
    logic [31:0] baseRd = 32'h0;
    logic [31:0] extRd  = 32'h0;
    logic        memInit = 1'b0;
    logic        prevCeLow = 1'b0;
    int cycleNum = 0;
    int lastCeFall = 0;
    int baseCeCycles = 0, extCeCycles = 0;
    int baseOeCycles = 0, extOeCycles = 0;
    int baseWeCycles = 0, extWeCycles = 0;
    int wfinCount = 0;
    logic [19:0] baseAddrSeen = 20'h0;
    logic [19:0] extAddrSeen  = 20'h0;

    assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n) ? baseRd : 32'bz;
    assign ext_ram_data  = (!ext_ram_ce_n && !ext_ram_oe_n) ? extRd : 32'bz;

    always @(negedge clk) begin
        if (!memInit) begin
            baseMem[20'h00004] = 32'h3401_0001;
            baseMem[20'h00100] = 32'h1111_2222;
            extMem[20'h00010]  = 32'hA5A5_5A5A;
            memInit = 1'b1;
        end
        cycleNum++;
        if ((!base_ram_ce_n || !ext_ram_ce_n) && !prevCeLow) lastCeFall = cycleNum;
        prevCeLow = !base_ram_ce_n || !ext_ram_ce_n;
        if (!base_ram_ce_n) begin baseCeCycles++; baseAddrSeen = base_ram_addr; end
        if (!ext_ram_ce_n)  begin extCeCycles++;  extAddrSeen  = ext_ram_addr;  end
        if (!base_ram_oe_n) baseOeCycles++;
        if (!ext_ram_oe_n)  extOeCycles++;
        if (!base_ram_we_n) baseWeCycles++;
        if (!ext_ram_we_n)  extWeCycles++;
        if (!base_ram_ce_n && !base_ram_we_n) baseMem[base_ram_addr] = base_ram_data;
        if (!ext_ram_ce_n && !ext_ram_we_n)   extMem[ext_ram_addr]   = ext_ram_data;
        if (wfin_a) wfinCount++;
        baseRd = baseMem.exists(base_ram_addr) ? baseMem[base_ram_addr] : 32'h0;
        extRd  = extMem.exists(ext_ram_addr) ? extMem[ext_ram_addr] : 32'h0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Snapshot of monitor counters at request time; deltas give per-access activity.
    int startCycle, sBaseCe, sExtCe, sBaseOe, sExtOe, sBaseWe, sExtWe, sWfin;

    task automatic takeSnapshot();
        startCycle = cycleNum;
        sBaseCe = baseCeCycles; sExtCe = extCeCycles;
        sBaseOe = baseOeCycles; sExtOe = extOeCycles;
        sBaseWe = baseWeCycles; sExtWe = extWeCycles;
        sWfin = wfinCount;
    endtask

    // kind: 0 fetch, 1 data read, 2 data write. Latency counts cycles after the sampling edge.
    task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                                 output int latency, output logic [31:0] data);
        logic fin;
        @(posedge clk); #1;
        rst = 1'b0;
        takeSnapshot();
        case (kind)
            0: begin irom_addr = addr; iread_ce = 1'b1; end
            1: begin drom_addr = addr; dread_ce = 1'b1; end
            default: begin drom_addr = addr; wdata = wd; dwrite_ce = 1'b1; end
        endcase
        @(posedge clk);
        latency = 0;
        data = 32'h0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            fin = (kind == 0) ? rfin_c : (kind == 1) ? rfin_a : wfin_a;
            if (fin) begin
                latency = n;
                data = (kind == 0) ? rom_inst : rom_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        iread_ce = 1'b0;
        dread_ce = 1'b0;
        dwrite_ce = 1'b0;
    endtask

    initial begin
        int lat;
        logic [31:0] rdata;
        int aCycle, cCycle, bothFin;
        logic [31:0] aData, cData;

        rst = 1'b1;
        iread_ce = 1'b1;
        irom_addr = 32'h8000_0010;
        dread_ce = 1'b0;
        dwrite_ce = 1'b0;
        drom_addr = 32'h0;
        wdata = 32'h0;

        $display("[TB] reset with fetch request held");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_strobes", 32'({base_ram_ce_n, base_ram_oe_n, base_ram_we_n,
                                        ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n}), 32'h3F);
        checkOutput("rst_fins", 32'({rfin_c, rfin_a, wfin_a}), 32'h0);
        checkOutput("rst_rom_inst", rom_inst, 32'h0);
        checkOutput("rst_rom_rdata", rom_rdata, 32'h0);
        checkOutput("rst_addr", 32'({base_ram_addr, ext_ram_addr[11:0]}), 32'h0);
        checkOutput("rst_be_n", 32'({base_ram_be_n, ext_ram_be_n}), 32'h0);

        $display("[TB] fetch from base after release");
        applyStimulus(0, 32'h8000_0010, 32'h0, lat, rdata);
        checkOutput("fetch_ce_fall_cycle", 32'(lastCeFall - startCycle - 1), 32'd1);
        checkOutput("fetch_latency", 32'(lat), 32'd3);
        checkOutput("fetch_data", rdata, 32'h3401_0001);
        checkOutput("fetch_oe_cycles", 32'(baseOeCycles - sBaseOe), 32'd2);
        checkOutput("fetch_addr", 32'(baseAddrSeen), 32'h00004);
        checkOutput("fetch_ext_idle", 32'(extCeCycles - sExtCe), 32'd0);

        $display("[TB] write then read on ext");
        applyStimulus(2, 32'h8040_0008, 32'hDEAD_BEEF, lat, rdata);
        checkOutput("wr_latency", 32'(lat), 32'd4);
        checkOutput("wr_we_cycles", 32'(extWeCycles - sExtWe), 32'd1);
        checkOutput("wr_ce_cycles", 32'(extCeCycles - sExtCe), 32'd3);
        checkOutput("wr_addr", 32'(extAddrSeen), 32'h00002);
        checkOutput("wr_base_idle", 32'(baseCeCycles - sBaseCe), 32'd0);
        checkOutput("wr_mem", extMem.exists(20'h00002) ? extMem[20'h00002] : 32'h0, 32'hDEAD_BEEF);
        applyStimulus(1, 32'h8040_0008, 32'h0, lat, rdata);
        checkOutput("rd_latency", 32'(lat), 32'd3);
        checkOutput("rd_data", rdata, 32'hDEAD_BEEF);
        checkOutput("rd_oe_cycles", 32'(extOeCycles - sExtOe), 32'd2);

        $display("[TB] data read versus fetch in the same cycle");
        @(posedge clk); #1;
        irom_addr = 32'h8000_0400;
        drom_addr = 32'h8040_0040;
        iread_ce = 1'b1;
        dread_ce = 1'b1;
        @(posedge clk);
        aCycle = 0; cCycle = 0; bothFin = 0;
        aData = 32'h0; cData = 32'h0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (rfin_a && rfin_c) bothFin++;
            if (rfin_a && aCycle == 0) begin aCycle = n; aData = rom_rdata; end
            if (rfin_c && cCycle == 0) begin cCycle = n; cData = rom_inst; end
            @(posedge clk); #1;
            if (aCycle != 0) dread_ce = 1'b0;
            if (cCycle != 0) begin iread_ce = 1'b0; break; end
        end
        iread_ce = 1'b0;
        dread_ce = 1'b0;
        checkOutput("prio_read_cycle", 32'(aCycle), 32'd3);
        checkOutput("prio_fetch_cycle", 32'(cCycle), 32'd7);
        checkOutput("prio_read_data", aData, 32'hA5A5_5A5A);
        checkOutput("prio_fetch_data", cData, 32'h1111_2222);
        checkOutput("prio_overlap", 32'(bothFin), 32'd0);

        $display("[TB] out-of-range accesses");
        applyStimulus(1, 32'hBFD0_03F8, 32'h0, lat, rdata);
        checkOutput("oor_rd_latency", 32'(lat), 32'd1);
        checkOutput("oor_rd_data", rdata, 32'h0);
        checkOutput("oor_rd_strobes", 32'((baseCeCycles - sBaseCe) + (extCeCycles - sExtCe)), 32'd0);
        applyStimulus(2, 32'hBFD0_03F8, 32'h1234_5678, lat, rdata);
        checkOutput("oor_wr_latency", 32'(lat), 32'd1);
        checkOutput("oor_wr_strobes", 32'((baseCeCycles - sBaseCe) + (extCeCycles - sExtCe)), 32'd0);
        checkOutput("oor_wr_mem", 32'(extMem.exists(20'h400FE)), 32'd0);

        $display("[TB] reset during write pulse");
        @(posedge clk); #1;
        takeSnapshot();
        drom_addr = 32'h8000_0020;
        wdata = 32'hCAFE_F00D;
        dwrite_ce = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort_in_pulse", 32'(base_ram_we_n), 32'd0);
        rst = 1'b1;
        dwrite_ce = 1'b0;
        @(negedge clk);
        checkOutput("abort_we_high", 32'({base_ram_we_n, base_ram_ce_n}), 32'h3);
        checkOutput("abort_rom_inst", rom_inst, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("abort_no_wfin", 32'(wfinCount - sWfin), 32'd0);
        applyStimulus(1, 32'h8000_0010, 32'h0, lat, rdata);
        checkOutput("abort_recover_latency", 32'(lat), 32'd3);
        checkOutput("abort_recover_data", rdata, 32'h3401_0001);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
